// File: rtl/crossing_sequencer.sv
// crossing_sequencer
// Sequencing controller for a two-track level crossing. Tracks occupancy on
// two approach tracks, runs the warning / lower / closed / raise sequence and
// supervises the gate limit switches with a timeout that latches a fault.
//
// Ports
//   clk            in   single clock, all state on rising edge
//   reset          in   synchronous, active-high
//   det_a, det_b   in   approach detector, track A / B (level)
//   clr_a, clr_b   in   exit (train-cleared) sensor, track A / B (level)
//   gate_down_ack  in   gate fully-down limit switch
//   gate_up_ack    in   gate fully-up limit switch
//   gate_cmd       out  00 hold, 01 lower, 10 raise
//   light          out  {red,yellow,green}, one-hot
//   state          out  current FSM state encoding
//   occupied       out  {track B, track A} occupancy flags
//   fault          out  sticky gate fault
module crossing_sequencer #(
  parameter int unsigned WARN_CYC     = 4,
  parameter int unsigned GATE_TIMEOUT = 8,
  parameter int unsigned CLEAR_HOLD   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       det_a,
  input  logic       det_b,
  input  logic       clr_a,
  input  logic       clr_b,
  input  logic       gate_down_ack,
  input  logic       gate_up_ack,
  output logic [1:0] gate_cmd,
  output logic [2:0] light,
  output logic [2:0] state,
  output logic [1:0] occupied,
  output logic       fault
);

  localparam int unsigned MAX_WG = (WARN_CYC > GATE_TIMEOUT) ? WARN_CYC : GATE_TIMEOUT;
  localparam int unsigned MAX_ALL = (MAX_WG > CLEAR_HOLD) ? MAX_WG : CLEAR_HOLD;
  localparam int unsigned CW = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] WARN_LAST  = CW'(WARN_CYC - 1);
  localparam logic [CW-1:0] GATE_LAST  = CW'(GATE_TIMEOUT - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    WARN   = 3'b001,
    LOWER  = 3'b010,
    CLOSED = 3'b011,
    RAISE  = 3'b100,
    FAULT  = 3'b101
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    occ_q, occ_d;
  logic          busy;

  assign busy = |occ_q;

  // Detector wins over a simultaneous clear so a train is never lost.
  always_comb begin
    occ_d    = occ_q;
    occ_d[0] = det_a | (occ_q[0] & ~clr_a);
    occ_d[1] = det_b | (occ_q[1] & ~clr_b);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
    end
  end

  // Next-state and shared counter
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (busy) state_d = WARN;
      end
      WARN: begin
        if (!busy)                  state_d = IDLE;
        else if (cnt_q == WARN_LAST) state_d = LOWER;
      end
      LOWER: begin
        if (gate_down_ack)           state_d = CLOSED;
        else if (cnt_q == GATE_LAST) state_d = FAULT;
      end
      CLOSED: begin
        if (!busy && cnt_q == CLEAR_LAST) state_d = RAISE;
      end
      RAISE: begin
        if (busy)                    state_d = LOWER;
        else if (gate_up_ack)        state_d = IDLE;
        else if (cnt_q == GATE_LAST) state_d = FAULT;
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase

    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == CLOSED && busy) begin
      // The clear-hold window restarts whenever any track is occupied.
      cnt_d = '0;
    end
  end

  // Output decode from registered state only
  always_comb begin
    gate_cmd = 2'b00;
    light    = 3'b100;
    fault    = 1'b0;
    case (state_q)
      IDLE:   begin gate_cmd = 2'b00; light = 3'b001; end
      WARN:   begin gate_cmd = 2'b00; light = 3'b010; end
      LOWER:  begin gate_cmd = 2'b01; light = 3'b100; end
      CLOSED: begin gate_cmd = 2'b00; light = 3'b100; end
      RAISE:  begin gate_cmd = 2'b10; light = 3'b010; end
      default: begin gate_cmd = 2'b01; light = 3'b100; fault = 1'b1; end
    endcase
  end

  assign state    = state_q;
  assign occupied = occ_q;

endmodule
